// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: multiplexed 4-digit common-anode FND driver.
// Cycles through the digits one slot at a time. Each slot is a DRIVE window
// followed by a short BLANK window that stops ghosting between digits. Each
// digit is decoded to active-low segments with a decimal point. Leading-zero
// suppression and per-digit blinking act by holding the digit's common line off.
//
// Interface: there is no valid/ready handshake. Every output is a register
// and is valid on every cycle. The digit inputs are sampled only on the edge
// that enters DRIVE, and that captured value is held for the whole slot.
module fnd_scan_ctrl #(
  parameter int  CLK_HZ       = 100_000_000,
  parameter int  SCAN_HZ      = 1000,
  parameter int  BLANK_CYCLES = 1000,
  parameter int  NUM_DIGITS   = 4,
  parameter int  BLINK_HZ     = 2,
  localparam int SEL_W        = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    lz_en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [SEL_W-1:0]        sel,
  output logic [NUM_DIGITS-1:0]   fnd_com,
  output logic [7:0]              fnd_data,
  output logic                    frame_tick,
  output logic [1:0]              state_dbg
);

  localparam int PERIOD     = CLK_HZ / SCAN_HZ;
  localparam int DRIVE_LEN  = PERIOD - BLANK_CYCLES;
  localparam int CNT_W      = $clog2(PERIOD);
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BLK_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_DRIVE = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [SEL_W-1:0]     sel_nx;
  logic [NUM_DIGITS-1:0] com_nx;
  logic [7:0]           data_nx;
  logic                 tick_nx;
  logic                 entry;
  logic [3:0]           nib;
  logic                 suppress;
  logic [BLK_W-1:0]     blink_cnt;
  logic                 blink_ph;

  // Active-low gfedcba pattern for a hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // True when every nibble from position idx up to the top digit is zero.
  function automatic logic upper_zero(input logic [4*NUM_DIGITS-1:0] d,
                                      input logic [SEL_W-1:0] idx);
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx) && d[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    end
  endfunction

  assign state_dbg = state;

  // Blink timebase: runs freely whatever en is, and toggles the phase every half period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BLK_W'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Scan state and registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_OFF;
      sel        <= '0;
      cnt        <= '0;
      fnd_com    <= '1;
      fnd_data   <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      cnt        <= cnt_nx;
      fnd_com    <= com_nx;
      fnd_data   <= data_nx;
      frame_tick <= tick_nx;
    end
  end

  // Next state, slot timing, and capture of the digit pattern on DRIVE entry.
  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    cnt_nx   = cnt;
    com_nx   = fnd_com;
    data_nx  = fnd_data;
    tick_nx  = 1'b0;
    entry    = 1'b0;
    nib      = 4'h0;
    suppress = 1'b0;

    if (!en) begin
      state_nx = S_OFF;
      sel_nx   = '0;
      cnt_nx   = '0;
      com_nx   = '1;
      data_nx  = 8'hFF;
    end else begin
      case (state)
        S_OFF: begin
          state_nx = S_DRIVE;
          sel_nx   = '0;
          cnt_nx   = '0;
          entry    = 1'b1;
        end
        S_DRIVE: begin
          if (cnt == CNT_W'(DRIVE_LEN - 1)) begin
            state_nx = S_BLANK;
            cnt_nx   = '0;
            com_nx   = '1;
            data_nx  = 8'hFF;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        S_BLANK: begin
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            state_nx = S_DRIVE;
            cnt_nx   = '0;
            sel_nx   = (sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel + 1'b1;
            tick_nx  = (sel == SEL_W'(NUM_DIGITS - 1));
            entry    = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = S_OFF;
          sel_nx   = '0;
          cnt_nx   = '0;
          com_nx   = '1;
          data_nx  = 8'hFF;
        end
      endcase
    end

    // Digit 0 is never blanked as a leading zero.
    if (entry) begin
      nib      = digits[{sel_nx, 2'b00} +: 4];
      suppress = (lz_en && (sel_nx != '0) && upper_zero(digits, sel_nx)) ||
                 (blink_mask[sel_nx] && blink_ph);
      com_nx   = suppress ? '1 : ~(NUM_DIGITS'(1) << sel_nx);
      data_nx  = {~dp_mask[sel_nx], seg7(nib)};
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: directed bench for fnd_scan_ctrl using the reduced-rate parameters.
// The driver queues the expected output word for every cycle it schedules.
// A monitor pops one word each falling edge and compares it with the outputs.
module tb_fnd_scan_ctrl;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en, lz_en;
  logic [15:0] digits;
  logic [3:0]  dp_mask, blink_mask;
  logic [1:0]  sel;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  logic        frame_tick;
  logic [1:0]  state_dbg;

  fnd_scan_ctrl #(
    .CLK_HZ      (1000),
    .SCAN_HZ     (100),
    .BLANK_CYCLES(2),
    .NUM_DIGITS  (4),
    .BLINK_HZ    (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .lz_en     (lz_en),
    .digits    (digits),
    .dp_mask   (dp_mask),
    .blink_mask(blink_mask),
    .sel       (sel),
    .fnd_com   (fnd_com),
    .fnd_data  (fnd_data),
    .frame_tick(frame_tick),
    .state_dbg (state_dbg)
  );

  // Scoreboard: bit 15 marks a word that must be checked.
  // Bits 14:0 hold {frame_tick, sel, fnd_com, fnd_data}.
  logic [15:0] exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [15:0] mon_w;
  logic [5:0]  blink_lit = 6'b100111;

  function automatic logic [15:0] mk(input logic ft, input logic [1:0] s,
                                     input logic [3:0] c, input logic [7:0] d);
    return {1'b1, ft, s, c, d};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s t=%0t: got tick=%0b sel=%0d com=%h data=%h, want tick=%0b sel=%0d com=%h data=%h",
               name, $time, act[14], act[13:12], act[11:8], act[7:0],
               want[14], want[13:12], want[11:8], want[7:0]);
    end
  endtask

  // Monitor: one expected word per falling edge while work is queued.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_w = exp_q.pop_front();
      if (mon_w[15]) check("scan", {frame_tick, sel, fnd_com, fnd_data}, mon_w[14:0]);
    end
  end

  // Driver: queue n copies of a word, then wait the n cycles it covers.
  task automatic expect_n(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // One full slot: 8 DRIVE cycles (tick only on the first), then 2 BLANK cycles.
  task automatic slot(input logic ft, input logic [1:0] s, input logic [3:0] c, input logic [7:0] d);
    expect_n(mk(ft, s, c, d), 1);
    expect_n(mk(1'b0, s, c, d), 7);
    expect_n(mk(1'b0, s, 4'hF, 8'hFF), 2);
  endtask

  // Watchdog.
  initial begin
    #200000;
    n_miss++;
    $display("FAIL watchdog: run did not complete within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Stimulus.
  initial begin
    rst = 1'b1; en = 1'b0; lz_en = 1'b0;
    digits = 16'h0000; dp_mask = 4'h0; blink_mask = 4'h0;
    #1 rst = 1'b0;
    #1 check("reset_async", {frame_tick, sel, fnd_com, fnd_data}, {1'b0, 2'd0, 4'hF, 8'hFF});
    repeat (2) @(negedge clk);
    #1;
    check("reset_held", {frame_tick, sel, fnd_com, fnd_data}, {1'b0, 2'd0, 4'hF, 8'hFF});
    rst = 1'b1;

    // Idle with the display disabled.
    expect_n(mk(1'b0, 2'd0, 4'hF, 8'hFF), 50);

    // Basic scan over two frames.
    en = 1'b1; digits = 16'h1234; dp_mask = 4'b0100;
    for (int f = 0; f < 2; f++) begin
      slot(f != 0, 2'd0, 4'hE, 8'h99);
      slot(1'b0,   2'd1, 4'hD, 8'hB0);
      slot(1'b0,   2'd2, 4'hB, 8'h24);
      slot(1'b0,   2'd3, 4'h7, 8'hF9);
    end

    // Leading-zero suppression.
    digits = 16'h0070; lz_en = 1'b1; dp_mask = 4'h0;
    slot(1'b1, 2'd0, 4'hE, 8'hC0);
    slot(1'b0, 2'd1, 4'hD, 8'hF8);
    slot(1'b0, 2'd2, 4'hF, 8'hC0);
    slot(1'b0, 2'd3, 4'hF, 8'hC0);
    digits = 16'h0000;
    slot(1'b1, 2'd0, 4'hE, 8'hC0);
    slot(1'b0, 2'd1, 4'hF, 8'hC0);
    slot(1'b0, 2'd2, 4'hF, 8'hC0);
    slot(1'b0, 2'd3, 4'hF, 8'hC0);

    // Mid-slot input change, then disable and re-enable during DRIVE.
    digits = 16'h1234; lz_en = 1'b0;
    expect_n(mk(1'b1, 2'd0, 4'hE, 8'h99), 1);
    expect_n(mk(1'b0, 2'd0, 4'hE, 8'h99), 2);
    digits = 16'hFFFF;
    expect_n(mk(1'b0, 2'd0, 4'hE, 8'h99), 5);
    expect_n(mk(1'b0, 2'd0, 4'hF, 8'hFF), 2);
    expect_n(mk(1'b0, 2'd1, 4'hD, 8'h8E), 3);
    en = 1'b0;
    expect_n(mk(1'b0, 2'd0, 4'hF, 8'hFF), 3);
    en = 1'b1;
    slot(1'b0, 2'd0, 4'hE, 8'h8E);
    expect_n(mk(1'b0, 2'd1, 4'hD, 8'h8E), 8);
    expect_n(mk(1'b0, 2'd1, 4'hF, 8'hFF), 1);

    // Asynchronous reset in the middle of a BLANK window.
    rst = 1'b0;
    #1 check("reset_mid_blank", {frame_tick, sel, fnd_com, fnd_data}, {1'b0, 2'd0, 4'hF, 8'hFF});
    @(negedge clk);
    #1 rst = 1'b1;
    slot(1'b0, 2'd0, 4'hE, 8'h8E);
    expect_n(mk(1'b0, 2'd1, 4'hD, 8'h8E), 1);

    // Blink on digit 0. A reset here aligns the blink phase with the new scan.
    rst = 1'b0; digits = 16'h0008; blink_mask = 4'b0001;
    @(negedge clk);
    #1 rst = 1'b1;
    for (int f = 0; f < 6; f++) begin
      slot(f != 0, 2'd0, blink_lit[f] ? 4'hE : 4'hF, 8'h80);
      slot(1'b0,   2'd1, 4'hD, 8'hC0);
      slot(1'b0,   2'd2, 4'hB, 8'hC0);
      slot(1'b0,   2'd3, 4'h7, 8'hC0);
    end

    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
